wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the 64-bit RISC-V NPC pipeline. It sits between the memory stage and the register file and is the only block that drives the register-file write port. It accepts completed instructions from MEM over a valid/ready handshake, buffers them in a small FIFO, and aligns and extends load data. It issues one register write per cycle, exposes the head entry for forwarding, and counts retired instructions.

## Interface
Parameters:
- DEPTH, 2: FIFO entries; power of two, at least 2.
- XLEN, 64: data width; matches `RegBus`.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  one clock; reset is asynchronous and active-low (rst==0 resets).
- mem_valid_i  in  1  MEM presents an instruction.
- mem_ready_o  out  1  stage can accept; = !full, forced 0 while rst==0.
- mem_we_i  in  1  instruction writes rd.
- mem_rd_i  in  5  destination register.
- mem_is_load_i  in  1  mem_data_i is a raw memory doubleword to be aligned.
- mem_funct3_i  in  3  load type (RV64I encoding).
- mem_addr_lo_i  in  3  load address bits [2:0].
- mem_data_i  in  XLEN  ALU result, or raw aligned doubleword when loading.
- wb_stall_i  in  1  hold the head entry; no dequeue.
- we_o  out  1  register-file write enable.
- waddr_o  out  5  register-file write address.
- wdata_o  out  XLEN  register-file write data.
- fwd_valid_o  out  1  head entry valid, writes rd, and rd!=0.
- fwd_rd_o  out  5  head entry rd.
- fwd_data_o  out  XLEN  head entry final data.
- retire_cnt_o  out  64  retired-instruction count.
- load_err_o  out  1  sticky: an enqueued load had funct3=111.

## Operation
- FIFO: write pointer, read pointer, and count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Enqueue when mem_valid_i && mem_ready_o. The stored entry is {we, rd, final_data}.
- final_data is computed combinationally before storage:
  - Non-load: mem_data_i unchanged.
  - Load, by funct3:
    - 000 lb: byte[addr_lo] sign-extended.
    - 001 lh: half[addr_lo[2:1]] sign-extended.
    - 010 lw: word[addr_lo[2]] sign-extended.
    - 011 ld: full doubleword.
    - 100 lbu, 101 lhu, 110 lwu: zero-extended.
    - 111: data 0, and load_err_o set.
  - Address bits below the access size are ignored; no misalignment trap in this block.
- Dequeue when count!=0 && !wb_stall_i.
- we_o = dequeue && head.we && head.rd!=0. waddr_o and wdata_o show the head fields whenever count!=0, and 0 when empty.
- fwd_* always reflect the head entry, including during a stall.
- retire_cnt_o increments by 1 on every dequeue, including entries with we=0 or rd=0. It wraps at 2^64.
- load_err_o is cleared only by reset.

## Timing
- Reset (async assert, sync-release expected upstream):
  - count, pointers, retire_cnt_o, load_err_o = 0.
  - we_o, waddr_o, wdata_o, fwd_* = 0.
  - mem_ready_o = 0 while rst==0, and 1 in the first cycle after release.
- Latency: an entry enqueued at edge N drives we_o during cycle N..N+1. The register file captures it at edge N+1. There is no same-cycle pass-through when empty.
- Full: mem_ready_o=0. mem_valid_i is ignored, and MEM must hold its payload.
- Simultaneous enqueue and dequeue (count between 1 and DEPTH-1): count unchanged, both pointers advance.
- Stall with a full FIFO: mem_ready_o stays 0, and the head is held stable on we_o-qualifying fields. we_o itself is 0 while stalled.
- Empty: no dequeue, we_o=0, retire count unchanged.
- Reset mid-operation: all buffered entries are discarded immediately, and no write is issued after rst falls.
- Order is strictly FIFO. At most one write per cycle.

## Test plan
- Reset, then enqueue {we=1, rd=5, data=0x1234} at edge 1 -> we_o=1, waddr_o=5, wdata_o=0x1234 in the following cycle, then retire_cnt_o=1.
- Load lb, addr_lo=3, raw=0x00000000_80000000 -> wdata_o=0xFFFFFFFF_FFFFFF80. Same raw with lbu -> 0x80. lwu addr_lo=4, raw=0xDEADBEEF_00000000 -> 0xDEADBEEF.
- Enqueue rd=0 with we=1 -> we_o=0, fwd_valid_o=0, retire_cnt_o still increments.
- Hold wb_stall_i=1 and push 3 entries with DEPTH=2 -> the third handshake blocks (mem_ready_o=0). Release the stall -> 3 writes in order on consecutive cycles.
- Back-to-back enqueue every cycle without stall -> mem_ready_o stays 1, and one write per cycle in order.
- Assert rst with 2 entries buffered -> outputs 0 immediately, and after release no stale writes appear. Separately, enqueue a load with funct3=111 -> load_err_o=1 until reset.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: buffers completed instructions from MEM in a small FIFO,
// aligns/extends load data on entry, and drives the single register-file write port.
module wb_stage #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid_i,
    output logic            mem_ready_o,
    input  logic            mem_we_i,
    input  logic [4:0]      mem_rd_i,
    input  logic            mem_is_load_i,
    input  logic [2:0]      mem_funct3_i,
    input  logic [2:0]      mem_addr_lo_i,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic            wb_stall_i,
    output logic            we_o,
    output logic [4:0]      waddr_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            fwd_valid_o,
    output logic [4:0]      fwd_rd_o,
    output logic [XLEN-1:0] fwd_data_o,
    output logic [63:0]     retire_cnt_o,
    output logic            load_err_o
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic            we;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_ent_t;

    wb_ent_t         fifo_q [DEPTH];
    wb_ent_t         head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            full, empty, enq, deq, load_bad;
    logic [XLEN-1:0] final_data;
    logic [7:0]      ld_b;
    logic [15:0]     ld_h;
    logic [31:0]     ld_w;

    // Sub-size address bits are dropped by the slice offsets; no misalignment check here.
    assign ld_b = mem_data_i[{mem_addr_lo_i, 3'b000} +: 8];
    assign ld_h = mem_data_i[{mem_addr_lo_i[2:1], 4'b0000} +: 16];
    assign ld_w = mem_data_i[{mem_addr_lo_i[2], 5'b00000} +: 32];

    always_comb begin
        final_data = mem_data_i;
        if (mem_is_load_i) begin
            unique case (mem_funct3_i)
                3'b000: final_data = {{(XLEN-8){ld_b[7]}}, ld_b};
                3'b001: final_data = {{(XLEN-16){ld_h[15]}}, ld_h};
                3'b010: final_data = {{(XLEN-32){ld_w[31]}}, ld_w};
                3'b011: final_data = mem_data_i;
                3'b100: final_data = {{(XLEN-8){1'b0}}, ld_b};
                3'b101: final_data = {{(XLEN-16){1'b0}}, ld_h};
                3'b110: final_data = {{(XLEN-32){1'b0}}, ld_w};
                3'b111: final_data = '0;
            endcase
        end
    end

    assign load_bad    = mem_is_load_i && (mem_funct3_i == 3'b111);
    assign full        = (count == (AW+1)'(DEPTH));
    assign empty       = (count == '0);
    assign mem_ready_o = rst && !full;
    assign enq         = mem_valid_i && mem_ready_o;
    assign deq         = !empty && !wb_stall_i;
    assign head        = fifo_q[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            retire_cnt_o <= '0;
            load_err_o   <= 1'b0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) begin
                rd_ptr       <= rd_ptr + 1'b1;
                retire_cnt_o <= retire_cnt_o + 64'd1;
            end
            if (enq && !deq)      count <= count + 1'b1;
            else if (!enq && deq) count <= count - 1'b1;
            if (enq && load_bad) load_err_o <= 1'b1;
        end
    end

    // Payload storage needs no reset: it is only observed through a non-zero count.
    always_ff @(posedge clk) begin
        if (enq) fifo_q[wr_ptr] <= '{we: mem_we_i, rd: mem_rd_i, data: final_data};
    end

    assign fwd_valid_o = !empty && head.we && (head.rd != 5'd0);
    assign fwd_rd_o    = empty ? 5'd0 : head.rd;
    assign fwd_data_o  = empty ? '0 : head.data;
    assign we_o        = fwd_valid_o && !wb_stall_i;
    assign waddr_o     = fwd_rd_o;
    assign wdata_o     = fwd_data_o;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: queue-based reference model compared every
// cycle, plus directed cases with hand-computed expectations.
module tb_wb_stage;

    localparam int DEPTH = 2;
    localparam int XLEN  = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            mem_valid_i = 1'b0, mem_we_i = 1'b0, mem_is_load_i = 1'b0, wb_stall_i = 1'b0;
    logic [4:0]      mem_rd_i = '0;
    logic [2:0]      mem_funct3_i = '0, mem_addr_lo_i = '0;
    logic [XLEN-1:0] mem_data_i = '0;
    logic            mem_ready_o, we_o, fwd_valid_o, load_err_o;
    logic [4:0]      waddr_o, fwd_rd_o;
    logic [XLEN-1:0] wdata_o, fwd_data_o;
    logic [63:0]     retire_cnt_o;

    wb_stage #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_we_i(mem_we_i),
        .mem_rd_i(mem_rd_i), .mem_is_load_i(mem_is_load_i), .mem_funct3_i(mem_funct3_i),
        .mem_addr_lo_i(mem_addr_lo_i), .mem_data_i(mem_data_i), .wb_stall_i(wb_stall_i),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
        .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o),
        .retire_cnt_o(retire_cnt_o), .load_err_o(load_err_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: shift the doubleword down to the naturally aligned slot, then mask/extend.
    function automatic logic [63:0] ref_data(input bit ld, input bit [2:0] f3,
                                              input bit [2:0] a, input bit [63:0] raw);
        int nb, off;
        logic [63:0] v, m;
        if (!ld) return raw;
        if (f3 == 3'd7) return 64'd0;
        nb  = 1 << f3[1:0];
        off = (int'(a) / nb) * nb;
        v   = raw >> (off * 8);
        if (nb < 8) begin
            m = (64'd1 << (nb * 8)) - 64'd1;
            v = v & m;
            if (!f3[2] && v[nb*8-1]) v = v | ~m;
        end
        return v;
    endfunction

    typedef struct {
        bit          we;
        bit [4:0]    rd;
        bit [63:0]   d;
    } ent_t;

    ent_t      mq[$];
    bit [63:0] m_retire = 0;
    bit        m_err = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_retire = 0;
            m_err    = 0;
        end else begin
            bit do_deq, do_enq;
            ent_t e;
            do_deq = (mq.size() != 0) && !wb_stall_i;
            do_enq = mem_valid_i && (mq.size() < DEPTH);
            if (do_deq) begin
                void'(mq.pop_front());
                m_retire = m_retire + 1;
            end
            if (do_enq) begin
                e.we = mem_we_i;
                e.rd = mem_rd_i;
                e.d  = ref_data(mem_is_load_i, mem_funct3_i, mem_addr_lo_i, mem_data_i);
                mq.push_back(e);
                if (mem_is_load_i && mem_funct3_i == 3'd7) m_err = 1;
            end
        end
    end

    always @(negedge clk) begin
        bit        has, fv;
        bit [4:0]  hrd;
        bit [63:0] hd;
        has = (mq.size() != 0);
        hrd = has ? mq[0].rd : 5'd0;
        hd  = has ? mq[0].d : 64'd0;
        fv  = has && mq[0].we && (mq[0].rd != 0);
        chk("ready", 64'(mem_ready_o), 64'(rst && (mq.size() < DEPTH)));
        chk("we", 64'(we_o), 64'(fv && !wb_stall_i));
        chk("waddr", 64'(waddr_o), 64'(hrd));
        chk("wdata", wdata_o, hd);
        chk("fwd_valid", 64'(fwd_valid_o), 64'(fv));
        chk("fwd_rd", 64'(fwd_rd_o), 64'(hrd));
        chk("fwd_data", fwd_data_o, hd);
        chk("retire", retire_cnt_o, m_retire);
        chk("load_err", 64'(load_err_o), 64'(m_err));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit we, input bit [4:0] rd, input bit [63:0] d,
                        input bit ld, input bit [2:0] f3, input bit [2:0] a);
        mem_valid_i = 1'b1; mem_we_i = we; mem_rd_i = rd; mem_data_i = d;
        mem_is_load_i = ld; mem_funct3_i = f3; mem_addr_lo_i = a;
        step();
        mem_valid_i = 1'b0;
        #1;
    endtask

    initial begin
        #1;
        chk("rst_ready", 64'(mem_ready_o), 64'd0);
        chk("rst_retire", retire_cnt_o, 64'd0);
        step(); step();
        rst = 1'b1;
        #1;
        chk("ready_after_release", 64'(mem_ready_o), 64'd1);

        push(1, 5'd5, 64'h1234, 0, 3'd0, 3'd0);
        chk("t1_we", 64'(we_o), 64'd1);
        chk("t1_waddr", 64'(waddr_o), 64'd5);
        chk("t1_wdata", wdata_o, 64'h1234);
        step();
        chk("t1_retire", retire_cnt_o, 64'd1);
        chk("t1_empty_we", 64'(we_o), 64'd0);

        push(1, 5'd7, 64'h0000_0000_8000_0000, 1, 3'b000, 3'd3);
        chk("lb", wdata_o, 64'hFFFF_FFFF_FFFF_FF80);
        push(1, 5'd7, 64'h0000_0000_8000_0000, 1, 3'b100, 3'd3);
        chk("lbu", wdata_o, 64'h80);
        push(1, 5'd8, 64'hDEAD_BEEF_0000_0000, 1, 3'b110, 3'd4);
        chk("lwu", wdata_o, 64'hDEAD_BEEF);
        push(1, 5'd0, 64'h55, 0, 3'd0, 3'd0);
        chk("rd0_we", 64'(we_o), 64'd0);
        chk("rd0_fwd", 64'(fwd_valid_o), 64'd0);
        step();
        chk("rd0_retire", retire_cnt_o, 64'd5);

        // Stall with the FIFO full, third handshake must block.
        wb_stall_i = 1'b1;
        push(1, 5'd10, 64'hA0, 0, 3'd0, 3'd0);
        push(1, 5'd11, 64'hA1, 0, 3'd0, 3'd0);
        mem_valid_i = 1'b1; mem_rd_i = 5'd12; mem_data_i = 64'hA2;
        #1;
        chk("full_ready", 64'(mem_ready_o), 64'd0);
        chk("stall_we", 64'(we_o), 64'd0);
        chk("stall_fwd_rd", 64'(fwd_rd_o), 64'd10);
        step();
        chk("full_ready2", 64'(mem_ready_o), 64'd0);
        wb_stall_i = 1'b0;
        #1;
        chk("drain0_we", 64'(we_o), 64'd1);
        chk("drain0_addr", 64'(waddr_o), 64'd10);
        step();
        chk("drain1_addr", 64'(waddr_o), 64'd11);
        step();
        mem_valid_i = 1'b0;
        #1;
        chk("drain2_we", 64'(we_o), 64'd1);
        chk("drain2_addr", 64'(waddr_o), 64'd12);
        step();
        chk("drained_we", 64'(we_o), 64'd0);
        chk("drained_retire", retire_cnt_o, 64'd8);

        // Back-to-back enqueue, no stall.
        for (int k = 1; k <= 16; k++) begin
            push(1, 5'(k), 64'(k * 3), 0, 3'd0, 3'd0);
            mem_valid_i = 1'b1;
            chk("b2b_ready", 64'(mem_ready_o), 64'd1);
            chk("b2b_addr", 64'(waddr_o), 64'(k));
        end
        mem_valid_i = 1'b0;
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            mem_valid_i   = ($urandom_range(0, 9) < 7);
            wb_stall_i    = ($urandom_range(0, 9) < 3);
            mem_we_i      = ($urandom_range(0, 7) != 0);
            mem_rd_i      = 5'($urandom_range(0, 31));
            mem_is_load_i = $urandom_range(0, 1) != 0;
            mem_funct3_i  = 3'($urandom_range(0, 7));
            mem_addr_lo_i = 3'($urandom_range(0, 7));
            mem_data_i    = {$urandom(), $urandom()};
            step();
        end
        mem_valid_i = 1'b0; wb_stall_i = 1'b0;
        step(); step(); step();

        // Reset with two entries buffered.
        wb_stall_i = 1'b1;
        push(1, 5'd20, 64'hB0, 0, 3'd0, 3'd0);
        push(1, 5'd21, 64'hB1, 0, 3'd0, 3'd0);
        rst = 1'b0;
        #1;
        chk("midrst_we", 64'(we_o), 64'd0);
        chk("midrst_fwd", 64'(fwd_valid_o), 64'd0);
        chk("midrst_waddr", 64'(waddr_o), 64'd0);
        chk("midrst_ready", 64'(mem_ready_o), 64'd0);
        chk("midrst_retire", retire_cnt_o, 64'd0);
        step(); step();
        rst = 1'b1; wb_stall_i = 1'b0;
        #1;
        chk("rel_ready", 64'(mem_ready_o), 64'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("no_stale_we", 64'(we_o), 64'd0);
            chk("no_stale_retire", retire_cnt_o, 64'd0);
        end

        // Illegal load type sets the sticky error.
        push(1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1, 3'b111, 3'd0);
        chk("err_set", 64'(load_err_o), 64'd1);
        chk("err_data", wdata_o, 64'd0);
        for (int k = 0; k < 4; k++) step();
        chk("err_sticky", 64'(load_err_o), 64'd1);
        rst = 1'b0;
        #1;
        chk("err_clear", 64'(load_err_o), 64'd0);
        step();
        rst = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
